flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface. Latches the Z/N/V flags that the ALU produces in EX, using per-opcode write masks.
- Evaluates the 3-bit branch condition of a B/BR instruction in ID against those flags and reports the taken/not-taken result to the PC logic.
- Handles the EX→ID flag hazard either by bypass or by a one-cycle stall FSM.
- Also keeps a saturating taken-branch counter for performance debug.

Parameters:
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pipe_stall  input  1  global pipeline freeze; no state updates while high.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_opcode  input  4  opcode of the EX instruction.
- alu_z  input  1  ALU zero flag for the EX instruction.
- alu_n  input  1  ALU negative flag.
- alu_v  input  1  ALU overflow flag.
- id_valid  input  1  ID stage holds a real instruction.
- id_opcode  input  4  opcode of the ID instruction.
- id_ccc  input  3  branch condition field of the ID instruction.
- flags  output  3  architectural flag register {Z,V,N}.
- br_stall  output  1  request a one-cycle ID stall for a flag hazard.
- br_valid  output  1  branch resolved this cycle.
- br_taken  output  1  resolved branch is taken; qualified by br_valid.
- taken_cnt  output  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (async, rst_n=0): flags=3'b000, FSM=RUN, taken_cnt=0. br_stall, br_valid and br_taken are 0 while reset is asserted.
- Flag write masks, applied when ex_valid & ~pipe_stall at the clock edge:
  - ADD 0000 and SUB 0001: write Z, N, V.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only.
  - All other opcodes: no write.
  - Unwritten bits hold their value.
- Branch detect: is_br = id_valid & (id_opcode==1100 | id_opcode==1101).
- Condition evaluation (ccc; Z,N,V taken from the effective flags):
  - 000 NE: Z==0
  - 001 EQ: Z==1
  - 010 GT: Z==0 & N==0
  - 011 LT: N==1
  - 100 GE: Z==1 | (Z==0 & N==0)
  - 101 LE: N==1 | Z==1
  - 110 OV: V==1
  - 111: always taken
- br_valid and br_taken are combinational from the current state and inputs (zero latency). Both are forced to 0 when pipe_stall=1.
- taken_cnt increments on a cycle with br_valid & br_taken & ~pipe_stall. It saturates at all-ones with no wrap.
- Hazard: hz = is_br & ex_valid & (EX opcode writes any flag).
- FSM without bypass:
  - RUN, hz=0: br_valid=is_br, using the flag register.
  - RUN, hz=1: br_stall=1, br_valid=0; next state HOLD.
  - HOLD: the register now holds the EX result. br_valid=is_br, br_stall=0; next state RUN.
  - pipe_stall=1 freezes the state; br_stall keeps its combinational value.
- Simultaneous flag write and branch resolve in the same cycle: evaluation uses the pre-write register unless bypassed (see Optional Feature).
- Reset mid-HOLD: return to RUN with flags cleared. A branch left in ID re-evaluates against zero flags.
- Opcodes 1000–1111 in EX never write flags, including HLT.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined:
  - Effective flags are per-bit muxed: an ALU bit replaces the register bit when the EX instruction writes that bit.
  - br_stall is tied 0 and the FSM is removed; every branch resolves in the same cycle.
- Undefined: the RUN/HOLD stall FSM above is used; the cost is one bubble per hazard.
- Architectural flag register contents are identical in both builds.

Decomposition:
- Shared package wisc_pkg holds:
  - opcode localparams (OP_ADD … OP_HLT)
  - ccc encodings (CC_NE … CC_UNC)
  - flag bit indices (FLG_Z=2, FLG_V=1, FLG_N=0)
  - a function returning the 3-bit write mask for an opcode
- One combinational sub-module, cond_eval (ccc + Z,N,V → taken). It is reused by any later branch-predict checker.

Test Plan:
- Reset, then ADD with alu_z=0, n=1, v=1 → flags=3'b011 next cycle; XOR with z=1 next → flags=3'b111 (N and V retained).
- Branch ccc=001 (EQ) in ID while SUB in EX produces z=1, with flags register Z=0. Without bypass: br_stall=1 one cycle, then br_valid=1, br_taken=1. With FLAG_BYPASS_EN: br_valid=1, br_taken=1 in the same cycle, br_stall=0.
- Sweep all 8 ccc values against all 8 {Z,V,N} states with no EX hazard → br_taken matches the table; ccc=111 always 1.
- pipe_stall=1 with an ADD in EX and a taken branch in ID → flags unchanged, br_valid=0, taken_cnt unchanged, FSM state held.
- Force taken_cnt to all-ones (CNT_W=4, preload via 15 taken branches), then one more taken branch → stays 4'hF.
- Assert rst_n=0 during HOLD → flags=0 and br_stall=0 immediately (async). After release with branch ccc=000 in ID and a non-flag opcode in EX → br_taken=1.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, branch condition codes, flag bit positions
// and the per-opcode flag write mask.
package wisc_pkg;

   typedef logic [2:0] flag_vec_t;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LLB    = 4'b1010;
   localparam logic [3:0] OP_LHB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   localparam logic [2:0] CC_NE  = 3'b000;
   localparam logic [2:0] CC_EQ  = 3'b001;
   localparam logic [2:0] CC_GT  = 3'b010;
   localparam logic [2:0] CC_LT  = 3'b011;
   localparam logic [2:0] CC_GE  = 3'b100;
   localparam logic [2:0] CC_LE  = 3'b101;
   localparam logic [2:0] CC_OV  = 3'b110;
   localparam logic [2:0] CC_UNC = 3'b111;

   localparam int FLG_Z = 2;
   localparam int FLG_V = 1;
   localparam int FLG_N = 0;

   // Which flag bits an EX instruction of this opcode overwrites.
   function automatic flag_vec_t flag_wr_mask(input logic [3:0] op);
      flag_vec_t mask;
      mask = '0;
      case (op)
         OP_ADD, OP_SUB: mask = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask[FLG_Z] = 1'b1;
         default: mask = '0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Pure combinational branch condition evaluator: 3-bit condition code and
// Z/N/V flags in, taken out.
module cond_eval
   import wisc_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic       z,
   input  logic       n,
   input  logic       v,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (ccc)
         CC_NE:  taken = ~z;
         CC_EQ:  taken = z;
         CC_GT:  taken = ~z & ~n;
         CC_LT:  taken = n;
         CC_GE:  taken = z | (~z & ~n);
         CC_LE:  taken = n | z;
         CC_OV:  taken = v;
         CC_UNC: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch resolution and taken-branch counter. Define
// FLAG_BYPASS_EN to forward EX flags into ID instead of stalling on a hazard.
module flag_branch_unit
   import wisc_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pipe_stall,
   input  logic             ex_valid,
   input  logic [3:0]       ex_opcode,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_v,
   input  logic             id_valid,
   input  logic [3:0]       id_opcode,
   input  logic [2:0]       id_ccc,
   output logic [2:0]       flags,
   output logic             br_stall,
   output logic             br_valid,
   output logic             br_taken,
   output logic [CNT_W-1:0] taken_cnt
);

   flag_vec_t        flags_reg;
   flag_vec_t        wr_mask;
   flag_vec_t        alu_flags;
   flag_vec_t        flags_next;
   flag_vec_t        eff_flags;
   logic             is_br;
   logic             resolve_ok;
   logic             stall_req;
   logic             cond_taken;
   logic [CNT_W-1:0] taken_cnt_reg;

   assign wr_mask = ex_valid ? flag_wr_mask(ex_opcode) : 3'b000;

   always_comb begin
      alu_flags        = '0;
      alu_flags[FLG_Z] = alu_z;
      alu_flags[FLG_V] = alu_v;
      alu_flags[FLG_N] = alu_n;
   end

   assign flags_next = (flags_reg & ~wr_mask) | (alu_flags & wr_mask);
   assign is_br      = id_valid & ((id_opcode == OP_B) | (id_opcode == OP_BR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_reg <= '0;
      end else if (!pipe_stall) begin
         flags_reg <= flags_next;
      end
   end

`ifdef FLAG_BYPASS_EN
   // Per-bit forwarding: flags_next already carries the EX result for written bits.
   assign eff_flags  = flags_next;
   assign resolve_ok = 1'b1;
   assign stall_req  = 1'b0;
`else
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0] state_reg;
   logic [0:0] state_next;
   logic       hz;

   assign hz        = is_br & (|wr_mask);
   assign eff_flags = flags_reg;

   // In HOLD the flag register already holds the producer's result.
   assign resolve_ok = (state_reg == ST_HOLD) | ~hz;
   assign stall_req  = (state_reg == ST_RUN) & hz;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:  if (hz) state_next = ST_HOLD;
         ST_HOLD: state_next = ST_RUN;
         default: state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_RUN;
      end else if (!pipe_stall) begin
         state_reg <= state_next;
      end
   end
`endif

   cond_eval u_cond_eval (
      .ccc   (id_ccc),
      .z     (eff_flags[FLG_Z]),
      .n     (eff_flags[FLG_N]),
      .v     (eff_flags[FLG_V]),
      .taken (cond_taken)
   );

   // Outputs are gated with rst_n so they read 0 for the whole reset window.
   assign br_valid = rst_n & ~pipe_stall & is_br & resolve_ok;
   assign br_taken = br_valid & cond_taken;
   assign br_stall = rst_n & stall_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt_reg <= '0;
      end else if (br_valid && br_taken && !pipe_stall && !(&taken_cnt_reg)) begin
         taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
      end
   end

   assign flags     = flags_reg;
   assign taken_cnt = taken_cnt_reg;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: table-driven condition sweep plus
// hand-written hazard, stall, saturation and reset sequences.
module tb_flag_branch_unit;
   import wisc_pkg::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pipe_stall;
   logic             ex_valid;
   logic [3:0]       ex_opcode;
   logic             alu_z;
   logic             alu_n;
   logic             alu_v;
   logic             id_valid;
   logic [3:0]       id_opcode;
   logic [2:0]       id_ccc;
   logic [2:0]       flags;
   logic             br_stall;
   logic             br_valid;
   logic             br_taken;
   logic [CNT_W-1:0] taken_cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0] ccc;
      logic [2:0] flg;   // {Z,V,N}
      logic       exp_taken;
   } vec_t;

   vec_t vecs [64];

   // Hand-derived truth masks per ccc, bit index = {Z,V,N}.
   logic [7:0] cc_mask [8];

   flag_branch_unit #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pipe_stall (pipe_stall),
      .ex_valid   (ex_valid),
      .ex_opcode  (ex_opcode),
      .alu_z      (alu_z),
      .alu_n      (alu_n),
      .alu_v      (alu_v),
      .id_valid   (id_valid),
      .id_opcode  (id_opcode),
      .id_ccc     (id_ccc),
      .flags      (flags),
      .br_stall   (br_stall),
      .br_valid   (br_valid),
      .br_taken   (br_taken),
      .taken_cnt  (taken_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle();
      pipe_stall = 1'b0;
      ex_valid   = 1'b0;
      ex_opcode  = OP_LW;
      alu_z      = 1'b0;
      alu_n      = 1'b0;
      alu_v      = 1'b0;
      id_valid   = 1'b0;
      id_opcode  = OP_ADD;
      id_ccc     = CC_NE;
   endtask

   task automatic ex_op(input logic [3:0] op, input logic z, input logic v, input logic n);
      ex_valid  = 1'b1;
      ex_opcode = op;
      alu_z     = z;
      alu_v     = v;
      alu_n     = n;
   endtask

   task automatic branch(input logic [2:0] cc);
      id_valid  = 1'b1;
      id_opcode = OP_B;
      id_ccc    = cc;
   endtask

   initial begin
      cc_mask[0] = 8'h0F;  // NE
      cc_mask[1] = 8'hF0;  // EQ
      cc_mask[2] = 8'h05;  // GT
      cc_mask[3] = 8'hAA;  // LT
      cc_mask[4] = 8'hF5;  // GE
      cc_mask[5] = 8'hFA;  // LE
      cc_mask[6] = 8'hCC;  // OV
      cc_mask[7] = 8'hFF;  // unconditional
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            vecs[c*8+f].ccc       = 3'(c);
            vecs[c*8+f].flg       = 3'(f);
            vecs[c*8+f].exp_taken = cc_mask[c][f];
         end
      end

      // Reset with a hazard-looking pair driven: outputs must stay 0.
      idle();
      rst_n = 1'b0;
      ex_op(OP_ADD, 1'b1, 1'b1, 1'b1);
      branch(CC_UNC);
      #12;
      chk("rst_flags", 32'(flags), 32'h0);
      chk("rst_cnt", 32'(taken_cnt), 32'h0);
      chk("rst_stall", 32'(br_stall), 32'h0);
      chk("rst_valid", 32'(br_valid), 32'h0);
      chk("rst_taken", 32'(br_taken), 32'h0);
      cyc();
      idle();
      rst_n = 1'b1;

      // Flag write masks.
      cyc();
      idle();
      ex_op(OP_ADD, 1'b0, 1'b1, 1'b1);
      cyc();
      chk("add_flags", 32'(flags), 32'h3);
      idle();
      ex_op(OP_XOR, 1'b1, 1'b0, 1'b0);
      cyc();
      chk("xor_flags", 32'(flags), 32'h7);
      idle();
      ex_op(OP_HLT, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("hlt_noflags", 32'(flags), 32'h7);
      idle();
      ex_op(OP_XOR, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("xor_z0", 32'(flags), 32'h3);

      // EQ branch behind a SUB that sets Z.
      idle();
      ex_op(OP_SUB, 1'b1, 1'b0, 1'b0);
      branch(CC_EQ);
      settle();
`ifdef FLAG_BYPASS_EN
      chk("hz_stall", 32'(br_stall), 32'h0);
      chk("hz_valid", 32'(br_valid), 32'h1);
      chk("hz_taken", 32'(br_taken), 32'h1);
      cyc();
      idle();
`else
      chk("hz_stall", 32'(br_stall), 32'h1);
      chk("hz_valid", 32'(br_valid), 32'h0);
      cyc();
      idle();
      branch(CC_EQ);
      settle();
      chk("hold_stall", 32'(br_stall), 32'h0);
      chk("hold_valid", 32'(br_valid), 32'h1);
      chk("hold_taken", 32'(br_taken), 32'h1);
      cyc();
      idle();
`endif
      chk("hz_flags", 32'(flags), 32'h4);
      chk("hz_cnt", 32'(taken_cnt), 32'h1);

      // Global freeze with a flag write and a taken branch both present.
      pipe_stall = 1'b1;
      ex_op(OP_ADD, 1'b0, 1'b1, 1'b1);
      branch(CC_UNC);
      settle();
      chk("ps_valid", 32'(br_valid), 32'h0);
      chk("ps_taken", 32'(br_taken), 32'h0);
`ifdef FLAG_BYPASS_EN
      chk("ps_stall", 32'(br_stall), 32'h0);
`else
      chk("ps_stall", 32'(br_stall), 32'h1);
`endif
      cyc();
      chk("ps_flags", 32'(flags), 32'h4);
      chk("ps_cnt", 32'(taken_cnt), 32'h1);
      pipe_stall = 1'b0;
      settle();
`ifdef FLAG_BYPASS_EN
      chk("ps_rel_valid", 32'(br_valid), 32'h1);
      cyc();
      idle();
`else
      chk("ps_rel_stall", 32'(br_stall), 32'h1);
      chk("ps_rel_valid", 32'(br_valid), 32'h0);
      cyc();
      idle();
      branch(CC_UNC);
      settle();
      chk("ps_hold_valid", 32'(br_valid), 32'h1);
      cyc();
      idle();
`endif
      chk("ps_after_flags", 32'(flags), 32'h3);
      chk("ps_after_cnt", 32'(taken_cnt), 32'h2);

      // Counter saturation from a clean reset.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (i == 15) chk("cnt_14", 32'(taken_cnt), 32'hE);
         if (i == 16) chk("cnt_15", 32'(taken_cnt), 32'hF);
         idle();
         branch(CC_UNC);
      end
      cyc();
      idle();
      chk("cnt_sat", 32'(taken_cnt), 32'hF);

      // Condition table sweep with no EX hazard.
      foreach (vecs[k]) begin
         cyc();
         idle();
         ex_op(OP_ADD, vecs[k].flg[2], vecs[k].flg[1], vecs[k].flg[0]);
         cyc();
         idle();
         branch(vecs[k].ccc);
         settle();
         chk($sformatf("sweep_valid_cc%0d_f%0d", vecs[k].ccc, vecs[k].flg),
             32'(br_valid), 32'h1);
         chk($sformatf("sweep_taken_cc%0d_f%0d", vecs[k].ccc, vecs[k].flg),
             32'(br_taken), 32'(vecs[k].exp_taken));
      end
      cyc();
      idle();

      // Async reset while a hazard is being held.
      ex_op(OP_ADD, 1'b1, 1'b0, 1'b0);
      branch(CC_NE);
      cyc();
      idle();
      branch(CC_NE);
      chk("pre_rst_flags", 32'(flags), 32'h4);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 32'(flags), 32'h0);
      chk("mid_rst_stall", 32'(br_stall), 32'h0);
      chk("mid_rst_valid", 32'(br_valid), 32'h0);
      cyc();
      rst_n = 1'b1;
      ex_op(OP_LW, 1'b1, 1'b1, 1'b1);
      branch(CC_NE);
      settle();
      chk("post_rst_stall", 32'(br_stall), 32'h0);
      chk("post_rst_valid", 32'(br_valid), 32'h1);
      chk("post_rst_taken", 32'(br_taken), 32'h1);
      cyc();
      idle();
      chk("post_rst_flags", 32'(flags), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
